kmeans_iter_ctrl: RTL

- Iteration sequencer in front of k_means_operator.
- Runs a host-programmed number of k-means passes. Per pass it:
  - pulses start_operator;
  - feeds centroids to the operator, from the host stream on pass 0 and from an internal buffer of the previous pass's updated centroids after that;
  - forwards the host tuple stream;
  - captures the operator's updated centroids.
- After the final pass it drains the buffered centroids to the host with full tready handshaking, which the operator output itself lacks.

---
 rtl/kmeans_iter_ctrl_pkg.sv | 8 +
 rtl/kmeans_cent_buf.sv | 50 +++++
 rtl/kmeans_iter_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/kmeans_iter_ctrl_pkg.sv
// kmeans_iter_ctrl_pkg: FSM state encoding, default sizes and error-flag bit indices for the k-means iteration controller
package kmeans_iter_ctrl_pkg;
  localparam int KM_CENT_DEPTH = 64;
  localparam int KM_ITER_BITS = 16;
  localparam int ERR_OVF = 0;
  localparam int ERR_LEN = 1;
  typedef enum logic [2:0] {S_IDLE, S_START, S_CENT, S_TUPLE, S_RES, S_DRAIN, S_DONE} iter_state_t;
endpackage

// File: rtl/kmeans_cent_buf.sv
// kmeans_cent_buf: simple dual-port centroid RAM (wr port; rd port 0..rd_len-1 through a registered valid/ready output stage, cleared while rd_en is low)
module kmeans_cent_buf #(
  parameter int DATA_BITS = 512,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [LW-1:0]        rd_len,
  output logic [DATA_BITS-1:0] m_tdata,
  output logic                 m_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready
);
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [DATA_BITS-1:0] data_q;
  logic [LW-1:0] rd_ptr_q;
  logic vld_q, last_q, adv;
  assign adv = rd_en && rd_ptr_q < rd_len && (!vld_q || m_tready);
  assign m_tdata = data_q;
  assign m_tlast = last_q;
  assign m_tvalid = vld_q;
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      rd_ptr_q <= '0;
      vld_q <= 1'b0;
      last_q <= 1'b0;
    end else if (!rd_en) begin
      rd_ptr_q <= '0;
      vld_q <= 1'b0;
      last_q <= 1'b0;
    end else if (adv) begin
      data_q <= mem[rd_ptr_q[AW-1:0]];
      vld_q <= 1'b1;
      last_q <= rd_ptr_q == rd_len - 1'b1;
      rd_ptr_q <= rd_ptr_q + 1'b1;
    end else if (m_tready) begin
      vld_q <= 1'b0;
    end
  end
endmodule

// File: rtl/kmeans_iter_ctrl.sv
// kmeans_iter_ctrl: runs num_iter k-means passes (host/buffered centroids + tuples to the operator, results captured) then drains final centroids on m_result
module kmeans_iter_ctrl
  import kmeans_iter_ctrl_pkg::*;
#(
  parameter int DATA_BITS = 512,
  parameter int CENT_DEPTH = KM_CENT_DEPTH,
  parameter int ITER_BITS = KM_ITER_BITS,
  localparam int KW = DATA_BITS / 8,
  localparam int AW = $clog2(CENT_DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 start,
  input  logic [ITER_BITS-1:0] num_iter,
  input  logic [LW-1:0]        cent_lines,
  input  logic [DATA_BITS-1:0] s_centroid_tdata,
  input  logic [KW-1:0]        s_centroid_tkeep,
  input  logic                 s_centroid_tlast,
  input  logic                 s_centroid_tvalid,
  output logic                 s_centroid_tready,
  input  logic [DATA_BITS-1:0] s_tuple_tdata,
  input  logic [KW-1:0]        s_tuple_tkeep,
  input  logic                 s_tuple_tlast,
  input  logic                 s_tuple_tvalid,
  output logic                 s_tuple_tready,
  output logic [DATA_BITS-1:0] m_op_centroid_tdata,
  output logic [KW-1:0]        m_op_centroid_tkeep,
  output logic                 m_op_centroid_tlast,
  output logic                 m_op_centroid_tvalid,
  input  logic                 m_op_centroid_tready,
  output logic [DATA_BITS-1:0] m_op_tuple_tdata,
  output logic [KW-1:0]        m_op_tuple_tkeep,
  output logic                 m_op_tuple_tlast,
  output logic                 m_op_tuple_tvalid,
  input  logic                 m_op_tuple_tready,
  input  logic [DATA_BITS-1:0] s_op_result_tdata,
  input  logic                 s_op_result_tlast,
  input  logic                 s_op_result_tvalid,
  output logic                 s_op_result_tready,
  output logic [DATA_BITS-1:0] m_result_tdata,
  output logic [KW-1:0]        m_result_tkeep,
  output logic                 m_result_tlast,
  output logic                 m_result_tvalid,
  input  logic                 m_result_tready,
  output logic                 start_operator,
  output logic                 um_done,
  output logic                 busy,
  output logic [ITER_BITS-1:0] iter_cnt,
  output logic [1:0]           err
);
  iter_state_t state_q, state_d;
  logic [ITER_BITS-1:0] iter_q, iter_d, niter_q, niter_d;
  logic [LW-1:0] lines_q, lines_d, wr_ptr_q, wr_ptr_d;
  logic [31:0] res_cnt_q, res_cnt_d;
  logic [1:0] err_q, err_d;
  logic rdy_q;
  logic cent_host, cent_buf, tuple, drain, in_res, res_v, wr_en, rd_en;
  logic buf_valid, buf_last, buf_ready;
  logic [DATA_BITS-1:0] buf_data;
  assign cent_host = state_q == S_CENT && iter_q == '0;
  assign cent_buf = state_q == S_CENT && iter_q != '0;
  assign tuple = state_q == S_TUPLE;
  assign drain = state_q == S_DRAIN;
  assign in_res = state_q == S_RES;
  assign res_v = s_op_result_tvalid && rdy_q;
  assign wr_en = res_v && in_res && wr_ptr_q < LW'(CENT_DEPTH);
  assign rd_en = cent_buf || drain;
  assign buf_ready = drain ? m_result_tready : m_op_centroid_tready;
  kmeans_cent_buf #(.DATA_BITS(DATA_BITS), .DEPTH(CENT_DEPTH)) u_buf (
    .clk(aclk),
    .rst(areset),
    .wr_en(wr_en),
    .wr_addr(wr_ptr_q[AW-1:0]),
    .wr_data(s_op_result_tdata),
    .rd_en(rd_en),
    .rd_len(lines_q),
    .m_tdata(buf_data),
    .m_tlast(buf_last),
    .m_tvalid(buf_valid),
    .m_tready(buf_ready)
  );
  assign s_centroid_tready = cent_host && m_op_centroid_tready;
  assign m_op_centroid_tvalid = cent_host ? s_centroid_tvalid : cent_buf && buf_valid;
  assign m_op_centroid_tdata = cent_host ? s_centroid_tdata : cent_buf ? buf_data : '0;
  assign m_op_centroid_tkeep = cent_host ? s_centroid_tkeep : {KW{cent_buf && buf_valid}};
  assign m_op_centroid_tlast = cent_host ? s_centroid_tlast : cent_buf && buf_valid && buf_last;
  assign s_tuple_tready = tuple && m_op_tuple_tready;
  assign m_op_tuple_tvalid = tuple && s_tuple_tvalid;
  assign m_op_tuple_tdata = tuple ? s_tuple_tdata : '0;
  assign m_op_tuple_tkeep = tuple ? s_tuple_tkeep : '0;
  assign m_op_tuple_tlast = tuple && s_tuple_tlast;
  assign s_op_result_tready = rdy_q;
  assign m_result_tvalid = drain && buf_valid;
  assign m_result_tdata = drain ? buf_data : '0;
  assign m_result_tkeep = {KW{m_result_tvalid}};
  assign m_result_tlast = m_result_tvalid && buf_last;
  assign start_operator = state_q == S_START;
  assign um_done = state_q == S_DONE;
  assign busy = state_q != S_IDLE;
  assign iter_cnt = iter_q;
  assign err = err_q;
  always_comb begin
    state_d = state_q;
    iter_d = iter_q;
    niter_d = niter_q;
    lines_d = lines_q;
    wr_ptr_d = wr_ptr_q + LW'(wr_en);
    res_cnt_d = res_cnt_q + 32'(res_v && in_res);
    err_d = err_q;
    if (res_v && !in_res) err_d[ERR_LEN] = 1'b1;
    if (res_v && in_res && !wr_en) err_d[ERR_OVF] = 1'b1;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_START;
        iter_d = '0;
        err_d = '0;
        niter_d = num_iter == '0 ? ITER_BITS'(1) : num_iter;
        lines_d = cent_lines == '0 ? LW'(1) : cent_lines;
        wr_ptr_d = '0;
        res_cnt_d = '0;
      end
      S_START: state_d = S_CENT;
      S_CENT: if (m_op_centroid_tvalid && m_op_centroid_tready && m_op_centroid_tlast) state_d = S_TUPLE;
      S_TUPLE: if (s_tuple_tvalid && s_tuple_tready && s_tuple_tlast) state_d = S_RES;
      S_RES: if (res_v && s_op_result_tlast) begin
        if (res_cnt_d != 32'(lines_q)) err_d[ERR_LEN] = 1'b1;
        if (iter_q + 1'b1 < niter_q) begin
          state_d = S_START;
          iter_d = iter_q + 1'b1;
          wr_ptr_d = '0;
          res_cnt_d = '0;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (m_result_tvalid && m_result_tready && m_result_tlast) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= S_IDLE;
      iter_q <= '0;
      niter_q <= '0;
      lines_q <= '0;
      wr_ptr_q <= '0;
      res_cnt_q <= '0;
      err_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q <= iter_d;
      niter_q <= niter_d;
      lines_q <= lines_d;
      wr_ptr_q <= wr_ptr_d;
      res_cnt_q <= res_cnt_d;
      err_q <= err_d;
      rdy_q <= 1'b1;
    end
  end
endmodule
